// File: rtl/gray_ptr_rx.sv
// rtl/gray_ptr_rx.sv - gray pointer receiver: 2-flop sync, binary decode, delta, illegal-jump tracking
module gray_ptr_rx #(
  parameter int BW_DATA   = 8,
  parameter int BW_ERRCNT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BW_DATA-1:0]   i_gray,
  input  logic                 i_clr,
  output logic [BW_DATA-1:0]   o_bin,
  output logic                 o_valid,
  output logic [BW_DATA-1:0]   o_delta,
  output logic                 o_err,
  output logic [BW_ERRCNT-1:0] o_err_cnt
);

  logic [BW_DATA-1:0] sync1;
  logic [BW_DATA-1:0] sync2;
  logic [BW_DATA-1:0] prev_gray;

  logic [BW_DATA-1:0] bin_cur;
  logic [BW_DATA-1:0] bin_prev;
  logic [BW_DATA-1:0] diff;
  logic               changed;
  logic               illegal;

  function automatic logic [BW_DATA-1:0] g2b(input logic [BW_DATA-1:0] g);
    logic [BW_DATA-1:0] b;
    b[BW_DATA-1] = g[BW_DATA-1];
    for (int k = BW_DATA - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  always_comb begin
    bin_cur  = g2b(sync2);
    bin_prev = g2b(prev_gray);
    diff     = sync2 ^ prev_gray;
    changed  = (diff != '0);
    // More than one bit set <=> clearing the lowest set bit leaves something behind
    illegal  = ((diff & (diff - {{(BW_DATA-1){1'b0}}, 1'b1})) != '0);
  end

  // Plain flop chain: nothing may sit between sync1 and sync2
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1     <= '0;
      sync2     <= '0;
      prev_gray <= '0;
    end else begin
      sync1     <= i_gray;
      sync2     <= sync1;
      prev_gray <= sync2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bin   <= '0;
      o_valid <= 1'b0;
      o_delta <= '0;
    end else begin
      o_bin   <= bin_cur;
      o_valid <= changed;
      o_delta <= bin_cur - bin_prev;
    end
  end

  // A new illegal transition beats a coincident clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else if (illegal) begin
      o_err <= 1'b1;
      if (i_clr)
        o_err_cnt <= {{(BW_ERRCNT-1){1'b0}}, 1'b1};
      else if (o_err_cnt != '1)
        o_err_cnt <= o_err_cnt + 1'b1;
    end else if (i_clr) begin
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb/tb_gray_ptr_rx.sv - scoreboard bench for gray_ptr_rx
module tb_gray_ptr_rx;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_gray = 8'h5A;
  logic       i_clr = 1'b0;
  logic [7:0] o_bin;
  logic       o_valid;
  logic [7:0] o_delta;
  logic       o_err;
  logic [7:0] o_err_cnt;

  gray_ptr_rx #(.BW_DATA(8), .BW_ERRCNT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_gray(i_gray), .i_clr(i_clr),
    .o_bin(o_bin), .o_valid(o_valid), .o_delta(o_delta),
    .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] delta;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] bin, input logic [7:0] delta,
                      input logic err, input logic [7:0] cnt);
    exp_t e;
    e.bin = bin; e.delta = delta; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    check(name, {7'd0, o_bin, o_valid, o_delta, o_err, o_err_cnt}, 32'd0);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Reset asserted between edges; outputs must already be zero before the next edge
  task automatic apply_reset(input logic [7:0] g);
    @(posedge i_clk);
    #3;
    i_rst  = 1'b1;
    i_gray = g;
    #1;
    check_zero("rst_async_zero");
    wait_neg(2);
    i_rst = 1'b0;
  endtask

  // Monitor: every o_valid pulse must match the head of the scoreboard
  always @(posedge i_clk) begin
    #1;
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got bin=%h delta=%h err=%b cnt=%0d expected no pulse",
                 o_bin, o_delta, o_err, o_err_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse", {7'd0, o_bin, o_delta, o_err, o_err_cnt}, {7'd0, e});
      end
    end
  end

  initial begin
    logic [7:0] g;
    logic [7:0] prev_g;

    // Reset with 0x5A held; first pulse after release decodes to 0x6C
    wait_neg(3);
    check_zero("reset_state");
    i_rst = 1'b0;
    push(8'h6C, 8'h6C, 1'b1, 8'd1);
    @(posedge i_clk); @(posedge i_clk); #1;
    check("lat_edge2_bin", o_bin, 8'h00);
    @(posedge i_clk); #1;
    check("lat_edge3_bin", o_bin, 8'h6C);
    wait_neg(5);
    check_drained("reset_pulse_seen");

    @(negedge i_clk) i_clr = 1'b1;
    @(negedge i_clk) i_clr = 1'b0;
    check("clr_alone", {o_err, o_err_cnt}, {1'b0, 8'd0});

    // Incrementing gray sequence
    apply_reset(8'h00);
    wait_neg(5);
    for (int i = 0; i < 100; i++) begin
      i_gray = 8'(i ^ (i >> 1));
      if (i > 0) push(8'(i), 8'h01, 1'b0, 8'd0);
      wait_neg(10);
      check("inc_bin", o_bin, 8'(i));
    end
    check_drained("inc_99_pulses");
    check("inc_no_err", o_err, 1'b0);

    // Wrap 255 -> 0, starting from 0x80 held through reset
    apply_reset(8'h80);
    push(8'hFF, 8'hFF, 1'b0, 8'd0);
    wait_neg(10);
    i_gray = 8'h00;
    push(8'h00, 8'h01, 1'b0, 8'd0);
    wait_neg(10);
    check("wrap_bin", o_bin, 8'h00);
    check_drained("wrap_pulses");

    // Illegal jump 0x00 -> 0x03, then hold
    i_gray = 8'h03;
    push(8'h02, 8'h02, 1'b1, 8'd1);
    wait_neg(20);
    check("illegal_hold", {o_err, o_err_cnt}, {1'b1, 8'd1});
    check_drained("illegal_single_pulse");

    // Bring counter to 5
    i_gray = 8'h0C; push(8'h08, 8'h06, 1'b1, 8'd2); wait_neg(10);
    i_gray = 8'h03; push(8'h02, 8'hFA, 1'b1, 8'd3); wait_neg(10);
    i_gray = 8'h0C; push(8'h08, 8'h06, 1'b1, 8'd4); wait_neg(10);
    i_gray = 8'h03; push(8'h02, 8'hFA, 1'b1, 8'd5); wait_neg(10);
    check("cnt_five", o_err_cnt, 8'd5);

    // Clear coincides with the compare edge of 0x03 -> 0x0C
    i_gray = 8'h0C;
    push(8'h08, 8'h06, 1'b1, 8'd1);
    wait_neg(2);
    i_clr = 1'b1;
    wait_neg(1);
    check("race_result", {o_err, o_err_cnt}, {1'b1, 8'd1});
    wait_neg(1);
    i_clr = 1'b0;
    check("race_then_clr", {o_err, o_err_cnt}, {1'b0, 8'd0});
    wait_neg(5);
    check_drained("race_pulses");

    // 300 illegal transitions saturate the counter
    prev_g = 8'h0C;
    for (int k = 1; k <= 300; k++) begin
      g = (k % 2 == 1) ? 8'h03 : 8'h0C;
      i_gray = g;
      push((g == 8'h03) ? 8'h02 : 8'h08,
           (g == 8'h03) ? 8'hFA : 8'h06,
           1'b1, (k > 255) ? 8'd255 : 8'(k));
      prev_g = g;
      wait_neg(3);
    end
    wait_neg(5);
    check("sat_cnt", o_err_cnt, 8'd255);
    check("sat_last_gray", {24'd0, prev_g}, 32'h0C);
    check_drained("sat_pulses");

    // Mid-run reset with a value in flight: no pulse may follow
    i_gray = 8'h03;
    apply_reset(8'h00);
    wait_neg(10);
    check_zero("post_reset_idle");
    check_drained("discard_in_flight");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_ptr_rx.md
GRAY_PTR_RX -- requirements
Module: gray_ptr_rx

Interface
REQ-001 Parameter BW_DATA, default 8, SHALL set the width of the gray-coded input and the binary output.
REQ-002 Parameter BW_ERRCNT, default 8, SHALL set the width of the error counter.
REQ-003 Port i_clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port i_rst, input, 1 bit, SHALL be the reset, asynchronous and active-high.
REQ-005 Port i_gray, input, BW_DATA bits, SHALL carry a gray-coded pointer launched from a foreign clock domain, asynchronous to i_clk.
REQ-006 Port i_clr, input, 1 bit, SHALL be a synchronous clear of the error status.
REQ-007 Port o_bin, output, BW_DATA bits, SHALL carry the registered binary decode of the synchronized pointer.
REQ-008 Port o_valid, output, 1 bit, SHALL pulse for one cycle when the synchronized pointer changes.
REQ-009 Port o_delta, output, BW_DATA bits, SHALL carry the modulo-2^BW_DATA binary advance since the previous value.
REQ-010 Port o_err, output, 1 bit, SHALL be a sticky flag for an illegal multi-bit gray transition.
REQ-011 Port o_err_cnt, output, BW_ERRCNT bits, SHALL count illegal transitions.

Function
REQ-012 Stage 1 (sync1) and stage 2 (sync2) SHALL form a two-flop synchronizer on i_gray, BW_DATA bits wide, with no logic between the flops.
REQ-013 Stage 3 SHALL hold prev_gray, which takes sync2 every cycle.
REQ-014 Each cycle, o_bin SHALL take g2b(sync2), where g2b gives bit k = XOR of gray bits BW_DATA-1 down to k.
REQ-015 Latency: a value held stable on i_gray before edge n SHALL appear on o_bin after edge n+2 (3 edges).
REQ-016 o_valid SHALL be 1 for exactly one cycle when sync2 != prev_gray at an edge, and 0 otherwise.
REQ-017 o_delta SHALL take g2b(sync2) - g2b(prev_gray), truncated to BW_DATA bits, every cycle; it is 0 when o_valid is 0.
REQ-018 Wrap-around: the transition from all-ones binary to zero SHALL give o_delta = 1 and no error.
REQ-019 Illegal transition: popcount(sync2 XOR prev_gray) > 1 at an edge SHALL set o_err to 1 in the same cycle o_valid is asserted.
REQ-020 o_err_cnt SHALL increment on each illegal transition.
REQ-021 o_err_cnt SHALL saturate at 2^BW_ERRCNT-1 without wrapping.
REQ-022 i_clr = 1 SHALL zero o_err and o_err_cnt on the next edge.
REQ-023 i_clr SHALL NOT affect the synchronizer, prev_gray, o_bin, o_valid or o_delta.
REQ-024 If i_clr and an illegal transition coincide, the set SHALL win: o_err = 1 and o_err_cnt = 1.
REQ-025 A single-bit legal transition SHALL leave o_err and o_err_cnt unchanged.

Reset
REQ-026 Asserting i_rst SHALL immediately force sync1, sync2, prev_gray, o_bin, o_valid, o_delta, o_err and o_err_cnt to 0, independent of i_clk.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight synchronizer data, with no pulse emitted for the discarded values.
REQ-028 After i_rst deasserts, the first edge SHALL sample i_gray normally.
REQ-029 A nonzero i_gray held through reset SHALL produce one o_valid pulse 3 edges after release, with o_delta = g2b(i_gray) and an error only if its popcount > 1.

Verification (BW_DATA = 8, BW_ERRCNT = 8)
REQ-030 Reset check: i_rst = 1 with i_gray = 0x5A -> all outputs 0; after release -> o_bin = 0x6C (g2b of 0x5A) after the 3rd edge, one o_valid pulse, o_delta = 0x6C, o_err = 1 and o_err_cnt = 1 (0x5A has popcount > 1).
REQ-031 Incrementing sequence: i_gray = bin2gray(i) for i = 0..99, one step per 10 cycles -> o_bin = i after 3 edges, exactly 99 o_valid pulses, each with o_delta = 1, and o_err = 0.
REQ-032 Wrap check: i_gray 0x80 (bin 255) -> 0x00 -> o_bin = 0x00, o_valid pulse, o_delta = 1, o_err = 0.
REQ-033 Illegal jump: i_gray 0x00 -> 0x03 -> o_bin = 0x02, o_delta = 0x02, o_valid = 1, o_err = 1, o_err_cnt = 1; holding 0x03 -> no further pulse.
REQ-034 Clear race: i_clr = 1 on the same edge as an illegal 0x03 -> 0x0C transition, with o_err_cnt previously 5 -> o_err = 1, o_err_cnt = 1; i_clr alone on the next cycle -> o_err = 0, o_err_cnt = 0.
REQ-035 Saturation and mid-run reset: 300 illegal transitions -> o_err_cnt = 255; then i_rst pulsed between clock edges -> all outputs 0 before the next edge.
